// File: rtl/sat_alu_pkg.sv
// Shared definitions for the saturating ALU pipeline.
// Holds the op encoding and saturation-limit constant functions.
package sat_alu_pkg;

    typedef enum logic [1:0] {
        ADD_SAT  = 2'b00,
        SUB_SAT  = 2'b01,
        PADD_SAT = 2'b10,
        ADD_WRAP = 2'b11
    } op_e;

    // Widest field the limit functions can describe.
    localparam int SAT_MAX_W = 64;

    // Largest positive two's-complement value of width w: 0 then ones.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
        sat_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of width w: 1 then zeros.
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
        sat_min = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cla_lane.sv
// One adder lane: sum with carry-in 0 plus group propagate/generate.
// Ports: a, b (W) operands; sum (W); p group propagate; g group generate.
module cla_lane #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         p,
    output logic         g
);

    always_comb begin
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
        sum = a ^ b ^ c[W-1:0];
        p   = &(a ^ b);
        g   = c[W];
    end

endmodule

// File: rtl/sat_alu_pipe.sv
// Two-stage saturating adder/subtractor with packed-lane mode.
// Ports: clk, rst (async high); in_valid/in_ready, op, a, b in;
//        out_valid/out_ready, result, ovf (per lane), cout out.
module sat_alu_pipe
    import sat_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [LANES-1:0]   ovf,
    output logic               cout
);

    localparam int LW = WIDTH / LANES;

    localparam logic [WIDTH-1:0] MAX_F = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_F = WIDTH'(sat_min(WIDTH));
    localparam logic [LW-1:0]    MAX_L = LW'(sat_max(LW));
    localparam logic [LW-1:0]    MIN_L = LW'(sat_min(LW));

    // ---------------- stage 1: per-lane sums ----------------
    op_e              op_in;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] lsum;
    logic [LANES-1:0] lp;
    logic [LANES-1:0] lg;
    logic [LANES-1:0] as_in;
    logic [LANES-1:0] bs_in;

    assign op_in = op_e'(op);
    // Subtraction inverts b here; the +1 enters as lane-0 carry in S2.
    assign bx    = (op_in == SUB_SAT) ? ~b : b;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cla_lane #(.W(LW)) u_lane (
            .a   (a[l*LW +: LW]),
            .b   (bx[l*LW +: LW]),
            .sum (lsum[l*LW +: LW]),
            .p   (lp[l]),
            .g   (lg[l])
        );
        assign as_in[l] = a[l*LW + LW - 1];
        assign bs_in[l] = bx[l*LW + LW - 1];
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_sum;
    logic [LANES-1:0] s1_p;
    logic [LANES-1:0] s1_g;
    logic [LANES-1:0] s1_as;
    logic [LANES-1:0] s1_bs;
    op_e              s1_op;

    logic s2_valid;
    logic s2_en;

    assign s2_en     = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_en;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_as    <= '0;
            s1_bs    <= '0;
            s1_op    <= ADD_SAT;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum <= lsum;
                s1_p   <= lp;
                s1_g   <= lg;
                s1_as  <= as_in;
                s1_bs  <= bs_in;
                s1_op  <= op_in;
            end
        end
    end

    // ---------------- stage 2: carry resolve + saturate ----------------
    logic [LANES:0]   c;
    logic [WIDTH-1:0] fsum;
    logic             f_ovf;
    logic [LANES-1:0] p_ovf;
    logic [WIDTH-1:0] res_n;
    logic [LANES-1:0] ovf_n;
    logic             cout_n;

    // Lane carries in flat sum-of-products form over group P/G,
    // so no lane waits on the lane below it.
    always_comb begin
        logic prod;
        c    = '0;
        c[0] = (s1_op == SUB_SAT);
        for (int l = 0; l < LANES; l++) begin
            prod = c[0];
            for (int k = 0; k <= l; k++) begin
                prod = prod & s1_p[k];
            end
            c[l+1] = prod;
            for (int j = 0; j <= l; j++) begin
                prod = s1_g[j];
                for (int k = j + 1; k <= l; k++) begin
                    prod = prod & s1_p[k];
                end
                c[l+1] = c[l+1] | prod;
            end
        end
    end

    always_comb begin
        fsum  = '0;
        p_ovf = '0;
        for (int l = 0; l < LANES; l++) begin
            fsum[l*LW +: LW] = s1_sum[l*LW +: LW] + LW'(c[l]);
            p_ovf[l] = (s1_as[l] == s1_bs[l])
                     & (s1_sum[l*LW + LW - 1] != s1_as[l]);
        end
        f_ovf = (s1_as[LANES-1] == s1_bs[LANES-1])
              & (fsum[WIDTH-1] != s1_as[LANES-1]);
    end

    always_comb begin
        res_n  = fsum;
        ovf_n  = '0;
        cout_n = c[LANES];
        unique case (s1_op)
            ADD_SAT, SUB_SAT: begin
                ovf_n[LANES-1] = f_ovf;
                if (f_ovf) begin
                    res_n = s1_as[LANES-1] ? MIN_F : MAX_F;
                end
            end
            ADD_WRAP: begin
                ovf_n[LANES-1] = f_ovf;
            end
            PADD_SAT: begin
                ovf_n  = p_ovf;
                cout_n = s1_g[LANES-1];
                for (int l = 0; l < LANES; l++) begin
                    if (p_ovf[l]) begin
                        res_n[l*LW +: LW] = s1_as[l] ? MIN_L : MAX_L;
                    end else begin
                        res_n[l*LW +: LW] = s1_sum[l*LW +: LW];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            result   <= '0;
            ovf      <= '0;
            cout     <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result <= res_n;
                ovf    <= ovf_n;
                cout   <= cout_n;
            end
        end
    end

endmodule
